alu_core_stage: RTL and testbench
=================================

ALU_CORE_STAGE -- requirements
Module: alu_core_stage

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 InValid  in  1  operands from the shift stage are valid this cycle.
REQ-005 Stall  in  1  hold all state.
REQ-006 Flush  in  1  discard the current op.
REQ-007 LHSIn  in  8  registered data from the LHS shift stage.
REQ-008 ShiftCarry  in  1  registered carry out of the LHS shift stage.
REQ-009 RHSIn  in  8  right-hand operand.
REQ-010 Op  in  3  000 PASS, 001 ADD, 010 ADC, 011 SUB, 100 SBC, 101 AND, 110 OR, 111 XOR.
REQ-011 FlagsWrite  in  1  op updates the flags register.
REQ-012 Result  out  8  registered result.
REQ-013 ResultValid  out  1  Result holds a completed op.
REQ-014 CarryFlag  out  1  registered carry; also fed back to the shift stage carry select.
REQ-015 ZeroFlag, SignFlag, OverflowFlag  out  1 each  registered flags.

Function
REQ-016 The block SHALL form "accept" = InValid & !Stall & !Flush.
REQ-017 Latency SHALL be exactly one cycle: an op accepted at edge N appears on Result/flags after edge N.
REQ-018 Arithmetic SHALL be 9-bit: ADD = LHS+RHS; ADC = LHS+RHS+CarryFlag; SUB = LHS+~RHS+1; SBC = LHS+~RHS+CarryFlag; carry = bit 8 (1 = no borrow for SUB/SBC).
REQ-019 PASS, AND, OR, XOR SHALL take carry from ShiftCarry, so that shift carry reaches CarryFlag.
REQ-020 ADC/SBC SHALL use the CarryFlag register value present before the edge; back-to-back ADC SHALL chain the carry correctly with no bubble.
REQ-021 ZeroFlag = (result==0), SignFlag = result[7].
REQ-022 On accept, Result SHALL load and ResultValid SHALL go 1; flags SHALL load only if FlagsWrite=1.
REQ-023 InValid=0, Stall=0, Flush=0: ResultValid SHALL go 0; Result and flags SHALL hold.
REQ-024 Stall=1, Flush=0: Result, ResultValid and all flags SHALL hold.
REQ-025 Flush=1 SHALL take priority over Stall and InValid: ResultValid SHALL go 0 and flags SHALL not update.

Reset
REQ-026 Reset assertion SHALL immediately, without a clock, force Result=0x00, ResultValid=0 and all flags=0.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight op.
REQ-028 The first accept after deassertion SHALL behave as a normal op.

Configuration
REQ-029 Macro ALU_OVERFLOW_FLAG_EN, defined: OverflowFlag SHALL be registered.
- Computed for ADD/ADC as (a7==b7)&(r7!=a7), where b = RHS.
- Computed for SUB/SBC with b = ~RHS.
- Set to 0 for PASS and the logic ops.
- Updated under the same rules as the other flags.
REQ-030 Macro undefined: OverflowFlag SHALL be constant 0 and no overflow register SHALL exist.
- All other behaviour SHALL be identical to the defined case.

Verification
REQ-031 ADD LHS=0xFF, RHS=0x01, FlagsWrite=1 -> next cycle Result=0x00, C=1, Z=1, S=0, ResultValid=1.
REQ-032 ADD 0xF0+0x20 (sets C=1), then ADC 0x00+0x00 on the next cycle -> second Result=0x01, C=0.
REQ-033 SUB 0x80-0x01 with ALU_OVERFLOW_FLAG_EN -> Result=0x7F, C=1, O=1, S=0; same stimulus without the macro -> O=0.
REQ-034 PASS with LHSIn=0x55, ShiftCarry=1, FlagsWrite=0 -> Result=0x55, ResultValid=1, flags unchanged.
REQ-035 Valid ADD held with Stall=1 for 3 cycles -> all outputs frozen; Stall+Flush together -> ResultValid=0, flags unchanged.
REQ-036 Reset pulsed between clock edges while ResultValid=1 and C=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_core_stage.sv
// Single-cycle ALU stage: registers the result and the C/Z/S/O flags from the shift-stage operands.
// Optional build macro ALU_OVERFLOW_FLAG_EN adds a registered overflow flag; otherwise OverflowFlag is tied to 0.
module alu_core_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       InValid,
    input  logic       Stall,
    input  logic       Flush,
    input  logic [7:0] LHSIn,
    input  logic       ShiftCarry,
    input  logic [7:0] RHSIn,
    input  logic [2:0] Op,
    input  logic       FlagsWrite,
    output logic [7:0] Result,
    output logic       ResultValid,
    output logic       CarryFlag,
    output logic       ZeroFlag,
    output logic       SignFlag,
    output logic       OverflowFlag
);

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADC  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SBC  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_XOR  = 3'b111
    } op_t;

    op_t        op_sel;
    logic [7:0] b_eff;
    logic       carry_in;
    logic [8:0] sum9;
    logic [7:0] alu_res;
    logic       alu_carry;
    logic       accept;

    assign op_sel = op_t'(Op);
    assign accept = InValid & ~Stall & ~Flush;

    // Subtraction is LHS + ~RHS + cin; ADC/SBC chain the pre-edge CarryFlag.
    always_comb begin
        b_eff    = RHSIn;
        carry_in = 1'b0;
        case (op_sel)
            OP_ADC:  carry_in = CarryFlag;
            OP_SUB:  begin b_eff = ~RHSIn; carry_in = 1'b1;      end
            OP_SBC:  begin b_eff = ~RHSIn; carry_in = CarryFlag; end
            default: ;
        endcase
    end

    assign sum9 = {1'b0, LHSIn} + {1'b0, b_eff} + {8'b0, carry_in};

    always_comb begin
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
        case (op_sel)
            OP_PASS: begin alu_res = LHSIn;         alu_carry = ShiftCarry; end
            OP_AND:  begin alu_res = LHSIn & RHSIn; alu_carry = ShiftCarry; end
            OP_OR:   begin alu_res = LHSIn | RHSIn; alu_carry = ShiftCarry; end
            OP_XOR:  begin alu_res = LHSIn ^ RHSIn; alu_carry = ShiftCarry; end
            default: ;
        endcase
    end

    // Flush beats Stall beats a normal accept; idle clears only ResultValid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Result      <= 8'h00;
            ResultValid <= 1'b0;
            CarryFlag   <= 1'b0;
            ZeroFlag    <= 1'b0;
            SignFlag    <= 1'b0;
        end else if (Flush) begin
            ResultValid <= 1'b0;
        end else if (!Stall) begin
            ResultValid <= InValid;
            if (accept) begin
                Result <= alu_res;
                if (FlagsWrite) begin
                    CarryFlag <= alu_carry;
                    ZeroFlag  <= (alu_res == 8'h00);
                    SignFlag  <= alu_res[7];
                end
            end
        end
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        case (op_sel)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC:
                alu_ovf = (LHSIn[7] == b_eff[7]) & (sum9[7] != LHSIn[7]);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            OverflowFlag <= 1'b0;
        end else if (accept && FlagsWrite) begin
            OverflowFlag <= alu_ovf;
        end
    end
`else
    assign OverflowFlag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core_stage.sv
// Scoreboard bench for alu_core_stage: directed vectors push expected outputs, a monitor pops and compares.
module tb_alu_core_stage;

`ifdef ALU_OVERFLOW_FLAG_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       InValid;
    logic       Stall;
    logic       Flush;
    logic [7:0] LHSIn;
    logic       ShiftCarry;
    logic [7:0] RHSIn;
    logic [2:0] Op;
    logic       FlagsWrite;
    logic [7:0] Result;
    logic       ResultValid;
    logic       CarryFlag;
    logic       ZeroFlag;
    logic       SignFlag;
    logic       OverflowFlag;

    alu_core_stage dut (
        .clk          (clk),
        .reset        (reset),
        .InValid      (InValid),
        .Stall        (Stall),
        .Flush        (Flush),
        .LHSIn        (LHSIn),
        .ShiftCarry   (ShiftCarry),
        .RHSIn        (RHSIn),
        .Op           (Op),
        .FlagsWrite   (FlagsWrite),
        .Result       (Result),
        .ResultValid  (ResultValid),
        .CarryFlag    (CarryFlag),
        .ZeroFlag     (ZeroFlag),
        .SignFlag     (SignFlag),
        .OverflowFlag (OverflowFlag)
    );

    typedef struct packed {
        logic       v, st, fl;
        logic [7:0] lhs;
        logic       sc;
        logic [7:0] rhs;
        logic [2:0] op;
        logic       fw;
        logic [7:0] res;
        logic       rv, c, z, s, o;   // o: expected overflow when the flag is built in
        logic [7:0] tag;
    } vec_t;

    typedef struct packed {
        logic [7:0] tag;
        logic [12:0] outs;            // {res, rv, c, z, s, o}
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [2:0] PASS = 3'd0, ADD = 3'd1, ADC = 3'd2, SUB = 3'd3,
                           SBC = 3'd4, AND = 3'd5, OR = 3'd6, XOR = 3'd7;

    function automatic vec_t mk(input logic v, st, fl, input logic [7:0] lhs, input logic sc,
                                input logic [7:0] rhs, input logic [2:0] op, input logic fw,
                                input logic [7:0] res, input logic rv, c, z, s, o,
                                input logic [7:0] tag);
        vec_t t;
        t = '{v, st, fl, lhs, sc, rhs, op, fw, res, rv, c, z, s, o, tag};
        return t;
    endfunction

    function automatic logic [12:0] outs_now();
        return {Result, ResultValid, CarryFlag, ZeroFlag, SignFlag, OverflowFlag};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: the DUT presents a registered output state every cycle; compare it just after the edge.
    initial begin
        exp_t e;
        logic [12:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = outs_now();
                n_vec++;
                if (act !== e.outs) begin
                    n_miss++;
                    $display("FAIL vec%0d {res,rv,c,z,s,o}: got %h/%b%b%b%b%b want %h/%b%b%b%b%b",
                             e.tag, act[12:5], act[4], act[3], act[2], act[1], act[0],
                             e.outs[12:5], e.outs[4], e.outs[3], e.outs[2], e.outs[1], e.outs[0]);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [12:0] want);
        logic [12:0] act;
        act = outs_now();
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic run_vec(input vec_t t);
        exp_t e;
        @(negedge clk);
        InValid = t.v; Stall = t.st; Flush = t.fl;
        LHSIn = t.lhs; ShiftCarry = t.sc; RHSIn = t.rhs; Op = t.op; FlagsWrite = t.fw;
        e.tag  = t.tag;
        e.outs = {t.res, t.rv, t.c, t.z, t.s, t.o & OV_EN};
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        InValid = 0; Stall = 0; Flush = 0; LHSIn = 0; ShiftCarry = 0;
        RHSIn = 0; Op = 0; FlagsWrite = 0;

        //            v st fl lhs    sc rhs    op    fw res    rv c  z  s  o  tag
        vecs.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h01, ADD,  1, 8'h00, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'hF0, 0, 8'h20, ADD,  1, 8'h10, 1, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, ADC,  1, 8'h01, 1, 0, 0, 0, 0, 3));
        vecs.push_back(mk(1, 0, 0, 8'h80, 0, 8'h01, SUB,  1, 8'h7F, 1, 1, 0, 0, 1, 4));
        vecs.push_back(mk(1, 0, 0, 8'h55, 1, 8'h00, PASS, 0, 8'h55, 1, 1, 0, 0, 1, 5));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'hAA, PASS, 1, 8'h00, 1, 0, 1, 0, 0, 6));
        vecs.push_back(mk(1, 0, 0, 8'h10, 0, 8'h05, SBC,  1, 8'h0A, 1, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 0, 0, 8'h10, 0, 8'h05, SBC,  1, 8'h0B, 1, 1, 0, 0, 0, 8));
        vecs.push_back(mk(1, 0, 0, 8'h7F, 0, 8'h01, ADD,  1, 8'h80, 1, 0, 0, 1, 1, 9));
        vecs.push_back(mk(1, 0, 0, 8'hF0, 1, 8'h3C, AND,  1, 8'h30, 1, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 0, 8'h0F, 0, 8'hF0, OR,   1, 8'hFF, 1, 0, 0, 1, 0, 11));
        vecs.push_back(mk(1, 0, 0, 8'hAA, 1, 8'hAA, XOR,  1, 8'h00, 1, 1, 1, 0, 0, 12));
        vecs.push_back(mk(0, 0, 0, 8'h12, 0, 8'h34, ADD,  1, 8'h00, 0, 1, 1, 0, 0, 13));
        vecs.push_back(mk(1, 0, 0, 8'h40, 0, 8'h40, ADD,  1, 8'h80, 1, 0, 0, 1, 1, 14));
        vecs.push_back(mk(1, 1, 0, 8'h01, 1, 8'h01, ADD,  1, 8'h80, 1, 0, 0, 1, 1, 15));
        vecs.push_back(mk(1, 1, 0, 8'h01, 1, 8'h01, ADD,  1, 8'h80, 1, 0, 0, 1, 1, 16));
        vecs.push_back(mk(1, 1, 0, 8'h01, 1, 8'h01, ADD,  1, 8'h80, 1, 0, 0, 1, 1, 17));
        vecs.push_back(mk(1, 1, 1, 8'h01, 1, 8'h01, ADD,  1, 8'h80, 0, 0, 0, 1, 1, 18));
        vecs.push_back(mk(1, 0, 1, 8'hFF, 1, 8'hFF, ADD,  1, 8'h80, 0, 0, 0, 1, 1, 19));
        vecs.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h00, ADC,  0, 8'hFF, 1, 0, 0, 1, 1, 20));
        vecs.push_back(mk(1, 0, 0, 8'hFF, 0, 8'h01, ADD,  1, 8'h00, 1, 1, 1, 0, 0, 21));
        // after the mid-cycle reset
        vecs.push_back(mk(1, 0, 0, 8'h01, 0, 8'h01, ADC,  1, 8'h02, 1, 0, 0, 0, 0, 22));
        vecs.push_back(mk(1, 0, 0, 8'h01, 0, 8'h02, ADD,  1, 8'h03, 1, 0, 0, 0, 0, 23));

        #12;
        check_now("reset_state", 13'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) run_vec(vecs[i]);

        // Vector 21 left ResultValid=1, C=1; pulse reset between edges with an op in flight.
        @(posedge clk);
        #3;
        InValid = 1; Op = ADD; LHSIn = 8'h11; RHSIn = 8'h22; FlagsWrite = 1;
        reset = 1'b1;
        #1;
        check_now("reset_async", 13'h0);
        @(posedge clk);
        #1;
        check_now("reset_hold_inflight", 13'h0);
        #2;
        reset = 1'b0;
        InValid = 0;

        for (int i = 21; i < 23; i++) run_vec(vecs[i]);

        @(negedge clk);
        InValid = 0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
